reg_shift_initiator: RTL and testbench

- Clocked initiator for the asynchronous save/left-shift register handshake.
- Accepts a command: optional parallel load, then N left shifts.
- Drives saveReq/leftReq and the register data input, and waits on the responder's saveFin/leftFin through synchronizers.
- Bridges synchronous control logic (datapath sequencers, multipliers) to the self-timed shift register.

---
 rtl/reg_hs_pkg.sv | 23 ++
 rtl/hs_sync.sv | 29 ++
 rtl/reg_shift_initiator.sv | 248 ++++++++++++++++++++++++
 tb/tb_reg_shift_initiator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_hs_pkg.sv
// reg_hs_pkg: shared types and defaults for the save/left-shift handshake initiator.
//   hs_state_e       - initiator FSM states
//   shift_cnt_width  - bits needed to hold a shift count of 0..Width
//   Def*             - default MinWait / ReqLow / Timeout cycle counts
package reg_hs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_HI,
        LEFT_HI,
        REQ_LO,
        DONE
    } hs_state_e;

    localparam int unsigned DefMinWait = 4;
    localparam int unsigned DefReqLow  = 2;
    localparam int unsigned DefTimeout = 256;

    function automatic int unsigned shift_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hs_sync.sv
// hs_sync: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module hs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reg_shift_initiator.sv
// reg_shift_initiator: clocked initiator for the self-timed save/left-shift register.
// A command optionally parallel-loads cmdData (save), then issues N left shifts.
// Each request is a four-phase-like level: req held high until the synchronized fin
// is accepted, then held low for at least ReqLow cycles.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cmdValid/cmdReady   - command handshake (ready only in IDLE)
//   cmdLoad, cmdShift,  - load flag, shift count (clamped to Width), load data
//   cmdData
//   regIn               - data presented to the register, held for the whole command
//   saveReq, leftReq    - requests to the responder (never both high)
//   saveFin, leftFin    - asynchronous completions from the responder
//   busy, done, err     - status; done/err are single-cycle pulses
//
// Optional feature macro: REG_SHIFT_TIMEOUT_EN
//   Defined   - a req held high for Timeout cycles is aborted with an err pulse and
//               the command is discarded (no done).
//   Undefined - reqs wait indefinitely and err is tied low.
//
// ReqLow is expected to be at least 1.
module reg_shift_initiator
    import reg_hs_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned MinWait = DefMinWait,
    parameter int unsigned ReqLow  = DefReqLow
`ifdef REG_SHIFT_TIMEOUT_EN
    ,
    parameter int unsigned Timeout = DefTimeout
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cmdValid,
    output logic                                cmdReady,
    input  logic                                cmdLoad,
    input  logic [shift_cnt_width(Width)-1:0]   cmdShift,
    input  logic [Width-1:0]                    cmdData,
    output logic [Width-1:0]                    regIn,
    output logic                                saveReq,
    output logic                                leftReq,
    input  logic                                saveFin,
    input  logic                                leftFin,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int unsigned CntW  = shift_cnt_width(Width);
    localparam int unsigned WaitW = $clog2(MinWait + 2);
    localparam int unsigned LoW   = $clog2(ReqLow + 1);

    hs_state_e        state_q, state_d;
    hs_state_e        next_q, next_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] reg_in_q, reg_in_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             seen_low_q, seen_low_d;
    logic [LoW-1:0]   lo_cnt_q, lo_cnt_d;
    logic             save_req_q, save_req_d;
    logic             left_req_q, left_req_d;
    logic             done_q, done_d;

`ifdef REG_SHIFT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(Timeout + 1);
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    logic             save_fin_s;
    logic             left_fin_s;
    logic             active_fin;
    logic             fin_ok;
    logic [CntW-1:0]  shift_clamped;

    hs_sync u_sync_save (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (saveFin),
        .q     (save_fin_s)
    );

    hs_sync u_sync_left (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (leftFin),
        .q     (left_fin_s)
    );

    assign shift_clamped = (cmdShift > CntW'(Width)) ? CntW'(Width) : cmdShift;

    // A high fin only counts once it is known to be fresh: either a low fin was seen
    // after the req rose, or MinWait cycles passed (covers a responder that finished
    // faster than the synchronizer could observe the low phase, and stale fins after reset).
    assign active_fin = (state_q == SAVE_HI) ? save_fin_s : left_fin_s;
    assign fin_ok     = active_fin && (seen_low_q || (wait_cnt_q >= WaitW'(MinWait)));

    always_comb begin
        state_d    = state_q;
        next_d     = next_q;
        count_d    = count_q;
        reg_in_d   = reg_in_q;
        wait_cnt_d = wait_cnt_q;
        seen_low_d = seen_low_q;
        lo_cnt_d   = lo_cnt_q;
        save_req_d = save_req_q;
        left_req_d = left_req_q;
        done_d     = 1'b0;
`ifdef REG_SHIFT_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    reg_in_d   = cmdData;
                    count_d    = shift_clamped;
                    wait_cnt_d = '0;
                    seen_low_d = 1'b0;
`ifdef REG_SHIFT_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                    if (cmdLoad) begin
                        state_d    = SAVE_HI;
                        save_req_d = 1'b1;
                    end else if (shift_clamped != '0) begin
                        state_d    = LEFT_HI;
                        left_req_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            SAVE_HI, LEFT_HI: begin
                if (!active_fin) begin
                    seen_low_d = 1'b1;
                end
                if (wait_cnt_q < WaitW'(MinWait)) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (fin_ok) begin
                    save_req_d = 1'b0;
                    left_req_d = 1'b0;
                    lo_cnt_d   = '0;
                    state_d    = REQ_LO;
                    if (state_q == LEFT_HI) begin
                        count_d = count_q - 1'b1;
                        next_d  = (count_q > CntW'(1)) ? LEFT_HI : DONE;
                    end else begin
                        next_d  = (count_q != '0) ? LEFT_HI : DONE;
                    end
                end
`ifdef REG_SHIFT_TIMEOUT_EN
                // Abort lands in REQ_LO so the low-time rule still holds before IDLE.
                else if (tmo_cnt_q == TmoW'(Timeout - 1)) begin
                    save_req_d = 1'b0;
                    left_req_d = 1'b0;
                    lo_cnt_d   = '0;
                    err_d      = 1'b1;
                    state_d    = REQ_LO;
                    next_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            REQ_LO: begin
                if (lo_cnt_q == LoW'(ReqLow - 1)) begin
                    state_d    = next_q;
                    wait_cnt_d = '0;
                    seen_low_d = 1'b0;
`ifdef REG_SHIFT_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                    if (next_q == LEFT_HI) begin
                        left_req_d = 1'b1;
                    end else if (next_q == DONE) begin
                        done_d = 1'b1;
                    end
                end else begin
                    lo_cnt_d = lo_cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                save_req_d = 1'b0;
                left_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            next_q     <= IDLE;
            count_q    <= '0;
            reg_in_q   <= '0;
            wait_cnt_q <= '0;
            seen_low_q <= 1'b0;
            lo_cnt_q   <= '0;
            save_req_q <= 1'b0;
            left_req_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef REG_SHIFT_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            next_q     <= next_d;
            count_q    <= count_d;
            reg_in_q   <= reg_in_d;
            wait_cnt_q <= wait_cnt_d;
            seen_low_q <= seen_low_d;
            lo_cnt_q   <= lo_cnt_d;
            save_req_q <= save_req_d;
            left_req_q <= left_req_d;
            done_q     <= done_d;
`ifdef REG_SHIFT_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign cmdReady = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign regIn    = reg_in_q;
    assign saveReq  = save_req_q;
    assign leftReq  = left_req_q;
    assign done     = done_q;
`ifdef REG_SHIFT_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_reg_shift_initiator.sv
// tb_reg_shift_initiator: self-checking bench for reg_shift_initiator.
// A behavioural responder models the self-timed shift register (save loads regIn,
// left shifts by one) and a scoreboard queue holds the expected register contents
// and request counts for each issued command, compared when done pulses.
// Optional feature macro: REG_SHIFT_TIMEOUT_EN (enables the timeout scenario).
module tb_reg_shift_initiator;
    import reg_hs_pkg::*;

    localparam int W      = 32;
    localparam int CW     = shift_cnt_width(W);
    localparam int ReqLo  = 2;
    localparam int TmoCyc = 64;

    logic          clk;
    logic          rst_n;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdLoad;
    logic [CW-1:0] cmdShift;
    logic [W-1:0]  cmdData;
    logic [W-1:0]  regIn;
    logic          saveReq;
    logic          leftReq;
    logic          saveFin;
    logic          leftFin;
    logic          busy;
    logic          done;
    logic          err;

    reg_shift_initiator #(
`ifdef REG_SHIFT_TIMEOUT_EN
        .Timeout (TmoCyc),
`endif
        .Width   (W),
        .MinWait (4),
        .ReqLow  (ReqLo)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdLoad  (cmdLoad),
        .cmdShift (cmdShift),
        .cmdData  (cmdData),
        .regIn    (regIn),
        .saveReq  (saveReq),
        .leftReq  (leftReq),
        .saveFin  (saveFin),
        .leftFin  (leftFin),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        int           saves;
        int           lefts;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] exp_reg;
    logic [W-1:0] model_reg;
    bit           save_stall;

    int n_checks;
    int n_pass;

    int save_rises, left_rises, done_pulses, err_pulses;
    int gap_viol, overlap_viol, regin_viol;
    int save_hi_run, last_save_hi_run;
    int base_save, base_left, base_done, base_err;

    // Behavioural self-timed register: clears fin on a req rise, completes after a
    // random delay, then holds fin high until the next req on that channel.
    initial begin
        saveFin   = 1'b0;
        leftFin   = 1'b0;
        model_reg = '0;
        forever begin
            @(posedge saveReq or posedge leftReq);
            if (saveReq) begin
                saveFin = 1'b0;
                if (!save_stall) begin
                    repeat ($urandom_range(5, 1)) @(posedge clk);
                    #1;
                    model_reg = regIn;
                    saveFin   = 1'b1;
                end
            end else begin
                leftFin = 1'b0;
                repeat ($urandom_range(5, 1)) @(posedge clk);
                #1;
                model_reg = model_reg << 1;
                leftFin   = 1'b1;
            end
        end
    end

    // Protocol monitor: counts req rises and pulses, and records any overlap,
    // short low gap between requests, or regIn change while a command is active.
    logic         prev_save, prev_left, prev_busy, had_req;
    int           low_run;
    logic [W-1:0] prev_regin;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_save = 1'b0;
            prev_left = 1'b0;
            prev_busy = 1'b0;
            had_req   = 1'b0;
            low_run   = 0;
        end else begin
            if (saveReq && !prev_save) save_rises++;
            if (leftReq && !prev_left) left_rises++;
            if ((saveReq && !prev_save) || (leftReq && !prev_left)) begin
                if (had_req && low_run < ReqLo) gap_viol++;
                had_req = 1'b1;
            end
            if (!saveReq && !leftReq) low_run++;
            else low_run = 0;
            if (saveReq && leftReq) overlap_viol++;
            if (saveReq) save_hi_run = prev_save ? save_hi_run + 1 : 1;
            else if (prev_save) last_save_hi_run = save_hi_run;
            if (busy && prev_busy && regIn !== prev_regin) regin_viol++;
            if (done) done_pulses++;
            if (err) err_pulses++;
            prev_save  = saveReq;
            prev_left  = leftReq;
            prev_busy  = busy;
            prev_regin = regIn;
        end
    end

    task automatic applyStimulus(input logic load, input int shift, input logic [W-1:0] data);
        exp_t e;
        int   eff;
        eff = (shift > W) ? W : shift;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (cmdReady) break;
        end
        e.saves  = load ? 1 : 0;
        e.lefts  = eff;
        e.out    = (load ? data : exp_reg) << eff;
        exp_reg  = e.out;
        sb.push_back(e);
        base_save = save_rises;
        base_left = left_rises;
        base_done = done_pulses;
        base_err  = err_pulses;
        cmdValid  = 1'b1;
        cmdLoad   = load;
        cmdShift  = CW'(shift);
        cmdData   = data;
        @(posedge clk);
        #1;
        cmdValid  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        cmdValid = 1'b0;
        cmdLoad  = 1'b0;
        cmdShift = '0;
        cmdData  = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (saveReq !== 1'b0) $display("[TB] FAIL reset_saveReq got %b want 0", saveReq); else n_pass++;
        n_checks++; if (leftReq !== 1'b0) $display("[TB] FAIL reset_leftReq got %b want 0", leftReq); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (cmdReady !== 1'b1) $display("[TB] FAIL reset_cmdReady got %b want 1", cmdReady); else n_pass++;
        n_checks++; if (regIn !== '0) $display("[TB] FAIL reset_regIn got %h want 0", regIn); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Load-only, load+shift and clamped-shift commands from a small table.
    task automatic test_commands();
        logic [W-1:0] d_tab[3];
        int           s_tab[3];
        exp_t         e;
        bit           got;
        d_tab[0] = 32'hA5A5_0001; s_tab[0] = 0;
        d_tab[1] = 32'h0000_0001; s_tab[1] = 4;
        d_tab[2] = 32'hFFFF_FFFF; s_tab[2] = 40;
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b1, s_tab[t], d_tab[t]);
            wait_done(5000, got);
            e = sb.pop_front();
            n_checks++; if (!got) $display("[TB] FAIL cmd%0d_done_timeout got no done want done", t); else n_pass++;
            n_checks++; if (model_reg !== e.out) $display("[TB] FAIL cmd%0d_out got %h want %h", t, model_reg, e.out); else n_pass++;
            n_checks++; if (save_rises - base_save != e.saves) $display("[TB] FAIL cmd%0d_saves got %0d want %0d", t, save_rises - base_save, e.saves); else n_pass++;
            n_checks++; if (left_rises - base_left != e.lefts) $display("[TB] FAIL cmd%0d_lefts got %0d want %0d", t, left_rises - base_left, e.lefts); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (done_pulses - base_done != 1) $display("[TB] FAIL cmd%0d_done_count got %0d want 1", t, done_pulses - base_done); else n_pass++;
        end
    endtask

    task automatic test_empty();
        exp_t e;
        applyStimulus(1'b0, 0, 32'hDEAD_BEEF);
        e = sb.pop_front();
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b1) $display("[TB] FAIL empty_done got %b want 1", done); else n_pass++;
        n_checks++; if (cmdReady !== 1'b0) $display("[TB] FAIL empty_ready_in_done got %b want 0", cmdReady); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0 || cmdReady !== 1'b1) $display("[TB] FAIL empty_after got done=%b ready=%b want done=0 ready=1", done, cmdReady); else n_pass++;
        n_checks++; if ((save_rises - base_save) + (left_rises - base_left) != 0) $display("[TB] FAIL empty_reqs got %0d want 0", (save_rises - base_save) + (left_rises - base_left)); else n_pass++;
        n_checks++; if (model_reg !== e.out) $display("[TB] FAIL empty_out got %h want %h", model_reg, e.out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   got;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(t != 2, $urandom_range(6, 0), $urandom);
            wait_done(3000, got);
            e = sb.pop_front();
            n_checks++; if (!got) $display("[TB] FAIL b2b%0d_done_timeout got no done want done", t); else n_pass++;
            n_checks++; if (model_reg !== e.out) $display("[TB] FAIL b2b%0d_out got %h want %h", t, model_reg, e.out); else n_pass++;
            n_checks++; if (left_rises - base_left != e.lefts || save_rises - base_save != e.saves) $display("[TB] FAIL b2b%0d_reqs got %0d/%0d want %0d/%0d", t, save_rises - base_save, left_rises - base_left, e.saves, e.lefts); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        applyStimulus(1'b1, 4, 32'h0000_0003);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (left_rises - base_left >= 2 && leftReq) begin
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        n_checks++; if (!got) $display("[TB] FAIL rmid_second_left got no leftReq want leftReq"); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (saveReq !== 1'b0 || leftReq !== 1'b0) $display("[TB] FAIL rmid_reqs got %b%b want 00", saveReq, leftReq); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cmdReady !== 1'b1) $display("[TB] FAIL rmid_state got busy=%b ready=%b want 0/1", busy, cmdReady); else n_pass++;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1, 32'h1234_5678);
        wait_done(3000, got);
        e = sb.pop_front();
        n_checks++; if (!got) $display("[TB] FAIL rpost_done_timeout got no done want done"); else n_pass++;
        n_checks++; if (model_reg !== e.out) $display("[TB] FAIL rpost_out got %h want %h", model_reg, e.out); else n_pass++;
        n_checks++; if (save_rises - base_save != 1 || left_rises - base_left != 1) $display("[TB] FAIL rpost_reqs got %0d/%0d want 1/1", save_rises - base_save, left_rises - base_left); else n_pass++;
    endtask

`ifdef REG_SHIFT_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit   got;
        save_stall = 1'b1;
        applyStimulus(1'b1, 2, 32'h0F0F_0F0F);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (err) begin
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        n_checks++; if (!got) $display("[TB] FAIL tmo_err got no err want err"); else n_pass++;
        n_checks++; if (last_save_hi_run != TmoCyc || saveReq !== 1'b0) $display("[TB] FAIL tmo_high_cycles got %0d want %0d", last_save_hi_run, TmoCyc); else n_pass++;
        repeat (ReqLo + 3) @(negedge clk);
        #1;
        n_checks++; if (err_pulses - base_err != 1) $display("[TB] FAIL tmo_err_count got %0d want 1", err_pulses - base_err); else n_pass++;
        n_checks++; if (done_pulses - base_done != 0 || left_rises - base_left != 0) $display("[TB] FAIL tmo_no_done got done=%0d lefts=%0d want 0/0", done_pulses - base_done, left_rises - base_left); else n_pass++;
        n_checks++; if (cmdReady !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL tmo_idle got ready=%b busy=%b want 1/0", cmdReady, busy); else n_pass++;
        save_stall = 1'b0;
    endtask
`endif

    task automatic checkOutput();
        n_checks++; if (overlap_viol != 0) $display("[TB] FAIL req_overlap got %0d want 0", overlap_viol); else n_pass++;
        n_checks++; if (gap_viol != 0) $display("[TB] FAIL req_low_gap got %0d want 0", gap_viol); else n_pass++;
        n_checks++; if (regin_viol != 0) $display("[TB] FAIL regin_stable got %0d want 0", regin_viol); else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        save_stall = 1'b0;
        exp_reg    = '0;
        $display("[TB] starting reg_shift_initiator bench");
        test_reset();
        test_commands();
        test_empty();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_SHIFT_TIMEOUT_EN
        test_timeout();
`endif
        checkOutput();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
